if_id_stage: RTL

//  IF->ID pipeline boundary of the 32-bit MIPS core, with a 2-entry skid buffer
//  and valid/ready handshakes on both sides.

---
 rtl/if_id_stage_if.sv | 36 +++
 rtl/if_id_stage.sv | 116 +++++++++++
 2 files changed

// File: rtl/if_id_stage_if.sv
// Handshake and decode-field bundle between fetch, the IF/ID boundary register and decode.
// The stage itself takes the slave view; fetch/decode (or a bench) take the master view.
interface if_id_stage_if #(
  parameter int PC_W = 32
);
  // fetch side
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc_plus4;
  logic            flush;
  // decode side
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [PC_W-1:0] out_pc_plus4;
  logic [5:0]      opcode;
  logic [4:0]      rs;
  logic [4:0]      rt;
  logic [4:0]      rd;
  logic [4:0]      shamt;
  logic [5:0]      funct;
  logic [15:0]     imm16;

  modport master (
    output in_valid, in_instr, in_pc_plus4, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc_plus4,
    input  opcode, rs, rt, rd, shamt, funct, imm16
  );

  modport slave (
    input  in_valid, in_instr, in_pc_plus4, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc_plus4,
    output opcode, rs, rt, rd, shamt, funct, imm16
  );
endinterface

// File: rtl/if_id_stage.sv
// IF->ID boundary: 2-entry skid buffer with registered in_ready, flush, and MIPS field split.
// The main register always drives the outputs; the skid entry only catches the word accepted during a stall.
module if_id_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          PC_W      = 32
) (
  input logic          Clk,
  input logic          Reset,
  if_id_stage_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } state_e;

  state_e          state_q;
  logic            out_valid_q;
  logic            in_ready_q;
  logic [31:0]     main_instr_q;
  logic [PC_W-1:0] main_pc_q;
  logic [31:0]     skid_instr_q;
  logic [PC_W-1:0] skid_pc_q;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = bus.in_valid & in_ready_q;
  assign out_xfer = out_valid_q & bus.out_ready;

  // Reset and flush clear identically; the main register is forced to the NOP image
  // whenever it goes idle so that outputs never need a valid-gated mux.
  always_ff @(posedge Clk) begin
    if (Reset || bus.flush) begin
      state_q      <= EMPTY;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      main_instr_q <= NOP_INSTR;
      main_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_instr_q <= bus.in_instr;
            main_pc_q    <= bus.in_pc_plus4;
            out_valid_q  <= 1'b1;
            state_q      <= FULL1;
          end
        end
        FULL1: begin
          if (out_xfer && in_xfer) begin
            main_instr_q <= bus.in_instr;
            main_pc_q    <= bus.in_pc_plus4;
          end else if (out_xfer) begin
            main_instr_q <= NOP_INSTR;
            main_pc_q    <= '0;
            out_valid_q  <= 1'b0;
            state_q      <= EMPTY;
          end else if (in_xfer) begin
            skid_instr_q <= bus.in_instr;
            skid_pc_q    <= bus.in_pc_plus4;
            in_ready_q   <= 1'b0;
            state_q      <= FULL2;
          end
        end
        FULL2: begin
          // in_ready is low here, so only the drain of main can happen.
          if (out_xfer) begin
            main_instr_q <= skid_instr_q;
            main_pc_q    <= skid_pc_q;
            in_ready_q   <= 1'b1;
            state_q      <= FULL1;
          end
        end
        default: begin
          state_q      <= EMPTY;
          out_valid_q  <= 1'b0;
          in_ready_q   <= 1'b1;
          main_instr_q <= NOP_INSTR;
          main_pc_q    <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_instr    = main_instr_q;
  assign bus.out_pc_plus4 = main_pc_q;

  assign bus.opcode = main_instr_q[31:26];
  assign bus.rs     = main_instr_q[25:21];
  assign bus.rt     = main_instr_q[20:16];
  assign bus.rd     = main_instr_q[15:11];
  assign bus.shamt  = main_instr_q[10:6];
  assign bus.funct  = main_instr_q[5:0];
  assign bus.imm16  = main_instr_q[15:0];

  // Structural invariants of the skid buffer.
  a_full2_not_ready: assert property (@(posedge Clk) disable iff (Reset)
    (state_q == FULL2) |-> !in_ready_q);

  a_valid_matches_state: assert property (@(posedge Clk) disable iff (Reset)
    out_valid_q == (state_q != EMPTY));

  a_idle_is_nop: assert property (@(posedge Clk) disable iff (Reset)
    !out_valid_q |-> (main_instr_q == NOP_INSTR && main_pc_q == '0));

  a_stall_hold: assert property (@(posedge Clk) disable iff (Reset)
    (out_valid_q && !bus.out_ready && !bus.flush) |=>
      (out_valid_q && $stable(main_instr_q) && $stable(main_pc_q)));

endmodule
